// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, bubble insertion and bubble counter
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic              Jump_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [1:0]        MemtoReg_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rd_i,
  input  logic [3:0]        funct_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              Branch_o,
  output logic              Jump_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic [1:0]        MemtoReg_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [3:0]        funct_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Control bundle packed as {RegWrite, MemRead, MemWrite, Branch, Jump, ALUSrc, ALUOp, MemtoReg};
  // all-zero is the nop encoding, so a bubble just clears it.
  localparam int CTRL_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CTRL_W-1:0] ctrl_d, ctrl_q, ctrl_in;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] pc_d, pc_q;
  logic [DATA_W-1:0] pc_plus4_d, pc_plus4_q;
  logic [DATA_W-1:0] rs1_data_d, rs1_data_q;
  logic [DATA_W-1:0] rs2_data_d, rs2_data_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  logic [4:0]        rs1_d, rs1_q;
  logic [4:0]        rs2_d, rs2_q;
  logic [4:0]        rd_d, rd_q;
  logic [3:0]        funct_d, funct_q;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;

  assign ctrl_in = {RegWrite_i, MemRead_i, MemWrite_i, Branch_i, Jump_i, ALUSrc_i, ALUOp_i, MemtoReg_i};

  // Next-state selection: flush beats stall beats normal load; default is hold.
  always_comb begin
    ctrl_d       = ctrl_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct_d      = funct_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush_i || !stall_i) begin
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      rs1_data_d = rs1_data_i;
      rs2_data_d = rs2_data_i;
      imm_d      = imm_i;
      rs1_d      = rs1_i;
      rs2_d      = rs2_i;
      funct_d    = funct_i;
    end

    if (flush_i) begin
      // rd is zeroed so forwarding comparators can never match a bubble.
      ctrl_d  = '0;
      valid_d = 1'b0;
      rd_d    = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (!stall_i) begin
      ctrl_d  = ctrl_in;
      valid_d = valid_i;
      rd_d    = rd_i;
    end
  end

  // State register with synchronous reset to the nop / all-zero state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q       <= '0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      pc_plus4_q   <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct_q      <= funct_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign {RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, ALUSrc_o, ALUOp_o, MemtoReg_o} = ctrl_q;
  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4_q;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign rs1_o        = rs1_q;
  assign rs2_o        = rs2_q;
  assign rd_o         = rd_q;
  assign funct_o      = funct_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk_i = 1'b0;
  logic rst_i, stall_i, flush_i, valid_i;
  logic RegWrite_i, MemRead_i, MemWrite_i, Branch_i, Jump_i, ALUSrc_i;
  logic [1:0] ALUOp_i, MemtoReg_i;
  logic [DATA_W-1:0] pc_i, pc_plus4_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic [3:0] funct_i;

  logic valid_o;
  logic RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, ALUSrc_o;
  logic [1:0] ALUOp_o, MemtoReg_o;
  logic [DATA_W-1:0] pc_o, pc_plus4_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [3:0] funct_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Branch_i(Branch_i), .Jump_i(Jump_i), .ALUSrc_i(ALUSrc_i),
    .ALUOp_i(ALUOp_i), .MemtoReg_i(MemtoReg_i),
    .pc_i(pc_i), .pc_plus4_i(pc_plus4_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .funct_i(funct_i),
    .valid_o(valid_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .Branch_o(Branch_o), .Jump_o(Jump_o), .ALUSrc_o(ALUSrc_o),
    .ALUOp_o(ALUOp_o), .MemtoReg_o(MemtoReg_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct_o(funct_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0; Branch_i = 0; Jump_i = 0; ALUSrc_i = 0;
    ALUOp_i = 2'b00; MemtoReg_i = 2'b00;
    pc_i = '0; pc_plus4_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    rs1_i = '0; rs2_i = '0; rd_i = '0; funct_i = '0; valid_i = 0;
  endtask

  function automatic logic [9:0] ctrl_out();
    return {RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, ALUSrc_o, ALUOp_o, MemtoReg_o};
  endfunction

  int exp_cnt;

  initial begin
    clear_inputs();
    rst_i = 1; stall_i = 0; flush_i = 0;
    // Non-zero inputs during reset must not leak to outputs.
    pc_i = 32'hdead_beef; rd_i = 5'd31; RegWrite_i = 1; valid_i = 1;
    step(); step();
    check("rst_ctrl", {22'd0, ctrl_out()}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_rd", {27'd0, rd_o}, 32'd0);
    check("rst_cnt", {28'd0, bubble_cnt_o}, 32'd0);

    // R-type add
    rst_i = 0; clear_inputs();
    RegWrite_i = 1; ALUOp_i = 2'b10; MemtoReg_i = 2'b01; rd_i = 5'd5; rs1_i = 5'd1; rs2_i = 5'd2;
    rs1_data_i = 32'd3; rs2_data_i = 32'd4; pc_i = 32'h100; pc_plus4_i = 32'h104; valid_i = 1;
    step();
    check("add_ctrl", {22'd0, ctrl_out()}, {22'd0, 10'b10_0000_1001});
    check("add_rd", {27'd0, rd_o}, 32'd5);
    check("add_rs1d", rs1_data_o, 32'd3);
    check("add_rs2d", rs2_data_o, 32'd4);
    check("add_rs1", {27'd0, rs1_o}, 32'd1);
    check("add_valid", {31'd0, valid_o}, 32'd1);
    check("add_cnt", {28'd0, bubble_cnt_o}, 32'd0);

    // Stream two instructions, stall on the second edge
    pc_i = 32'h200; rd_i = 5'd8; imm_i = 32'hffff_fff0; funct_i = 4'h8;
    step();
    check("s1_pc", pc_o, 32'h200);
    check("s1_funct", {28'd0, funct_o}, 32'h8);
    pc_i = 32'h204; rd_i = 5'd9; imm_i = 32'h0000_0004; funct_i = 4'h2; RegWrite_i = 0; stall_i = 1;
    step();
    check("stall_pc", pc_o, 32'h200);
    check("stall_rd", {27'd0, rd_o}, 32'd8);
    check("stall_imm", imm_o, 32'hffff_fff0);
    check("stall_rw", {31'd0, RegWrite_o}, 32'd1);
    stall_i = 0;
    step();
    check("s2_pc", pc_o, 32'h204);
    check("s2_rd", {27'd0, rd_o}, 32'd9);
    check("s2_rw", {31'd0, RegWrite_o}, 32'd0);

    // lw then flush with stall
    clear_inputs();
    RegWrite_i = 1; MemRead_i = 1; ALUSrc_i = 1; rd_i = 5'd7; valid_i = 1; pc_i = 32'h208;
    step();
    check("lw_memrd", {31'd0, MemRead_o}, 32'd1);
    check("lw_rd", {27'd0, rd_o}, 32'd7);
    pc_i = 32'h300; imm_i = 32'h10; rd_i = 5'd12; flush_i = 1; stall_i = 1;
    step();
    check("fl_ctrl", {22'd0, ctrl_out()}, 32'd0);
    check("fl_rd", {27'd0, rd_o}, 32'd0);
    check("fl_valid", {31'd0, valid_o}, 32'd0);
    check("fl_cnt", {28'd0, bubble_cnt_o}, 32'd1);
    check("fl_pc", pc_o, 32'h300);
    check("fl_imm", imm_o, 32'h10);

    // Saturation: 20 more flush edges with 4-bit counter
    stall_i = 0;
    exp_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt < 15) exp_cnt++;
      check("sat_cnt", {28'd0, bubble_cnt_o}, exp_cnt);
    end
    check("sat_final", {28'd0, bubble_cnt_o}, 32'd15);

    // jal then reset during stall
    flush_i = 0; clear_inputs();
    Jump_i = 1; RegWrite_i = 1; MemtoReg_i = 2'b10; pc_i = 32'h100; pc_plus4_i = 32'h104;
    rd_i = 5'd1; valid_i = 1;
    step();
    check("jal_jump", {31'd0, Jump_o}, 32'd1);
    check("jal_m2r", {30'd0, MemtoReg_o}, 32'd2);
    check("jal_pc4", pc_plus4_o, 32'h104);
    rst_i = 1; stall_i = 1; flush_i = 1;
    step();
    check("mrst_ctrl", {22'd0, ctrl_out()}, 32'd0);
    check("mrst_pc4", pc_plus4_o, 32'd0);
    check("mrst_valid", {31'd0, valid_o}, 32'd0);
    check("mrst_cnt", {28'd0, bubble_cnt_o}, 32'd0);
    rst_i = 0; stall_i = 0; flush_i = 0;
    clear_inputs();
    RegWrite_i = 1; ALUOp_i = 2'b10; MemtoReg_i = 2'b01; pc_plus4_i = 32'h208; rd_i = 5'd3; valid_i = 1;
    step();
    check("post_pc4", pc_plus4_o, 32'h208);
    check("post_rd", {27'd0, rd_o}, 32'd3);
    check("post_valid", {31'd0, valid_o}, 32'd1);
    check("post_cnt", {28'd0, bubble_cnt_o}, 32'd0);

    // One flush, then valid_i=0 with nop controls must not count
    flush_i = 1;
    step();
    check("one_fl_cnt", {28'd0, bubble_cnt_o}, 32'd1);
    flush_i = 0; clear_inputs(); rd_i = 5'd4; pc_i = 32'h40;
    step();
    check("nop_valid", {31'd0, valid_o}, 32'd0);
    check("nop_cnt", {28'd0, bubble_cnt_o}, 32'd1);
    check("nop_ctrl", {22'd0, ctrl_out()}, 32'd0);
    check("nop_rd", {27'd0, rd_o}, 32'd4);
    check("nop_pc", pc_o, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage RISC-V core.
- Captures the decoder's control bundle, register-file read data, immediate, PC values and register indices each cycle.
- Supports hold (stall) and bubble insertion (flush / load-use).
- Keeps a valid bit and a saturating count of inserted bubbles for performance debug.

Parameters:
- DATA_W, 32, width of PC, register data and immediate paths.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold all contents; no update this cycle.
- flush_i  in  1  insert a bubble: control cleared, valid cleared.
- valid_i  in  1  ID stage holds a real instruction.
- RegWrite_i, MemRead_i, MemWrite_i, Branch_i, Jump_i, ALUSrc_i  in  1 each  decoder control bits.
- ALUOp_i  in  2  decoder ALU class.
- MemtoReg_i  in  2  writeback select: 00 memory, 01 ALU, 10 pc+4.
- pc_i, pc_plus4_i  in  DATA_W  ID-stage PC and PC+4.
- rs1_data_i, rs2_data_i  in  DATA_W  register-file read data.
- imm_i  in  DATA_W  sign-extended immediate.
- rs1_i, rs2_i, rd_i  in  5 each  register indices (used for forwarding and hazard detection).
- funct_i  in  4  {instr[30], instr[14:12]} for ALU control.
- Each *_i above except clk_i, rst_i, stall_i, flush_i has a same-width *_o output: registered copy visible to EX.
- valid_o  out  1  EX stage holds a real instruction.
- bubble_cnt_o  out  CNT_W  number of bubbles inserted since reset, saturating.

Behaviour:
- Update priority per rising edge: rst_i > flush_i > stall_i > normal load.
- Reset:
  - All outputs go to 0, including control, data, indices, valid_o and bubble_cnt_o.
  - The all-zero control state is the nop encoding: no RegWrite, no MemRead/MemWrite, no Branch/Jump, ALUOp 00, MemtoReg 00.
- Flush:
  - Control outputs (RegWrite, MemRead, MemWrite, Branch, Jump, ALUSrc, ALUOp, MemtoReg) are cleared to 0.
  - valid_o is cleared to 0, and rd_o is cleared to 0 so forwarding logic never matches.
  - Data fields (pc, pc_plus4, rs1/rs2 data, imm, rs1, rs2, funct) load from their inputs, which is don't-care but deterministic.
  - flush_i overrides stall_i when both are asserted.
- Stall (flush_i=0): every output holds its previous value; bubble_cnt_o is unchanged.
- Normal load: every *_o takes *_i on the edge; valid_o takes valid_i.
- valid_i=0 with no stall or flush:
  - Control loads as presented; the decoder's default case already drives nop controls.
  - This is not counted as a bubble.
- Latency: exactly 1 cycle from input to output; no combinational path from input to output.
- Bubble counter:
  - Increments by 1 on each edge where flush_i=1 and rst_i=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Counts regardless of valid_i and stall_i.
- Reset mid-stall or mid-flush: reset wins; the next cycle after release loads normally.
- Outputs are reset to defined values, so no X ever appears on outputs after reset.

Test Plan:
1. Reset, then load R-type add (RegWrite=1, ALUOp=10, MemtoReg=01, rd=5, rs1_data=3, rs2_data=4, valid_i=1) -> next cycle outputs match exactly, valid_o=1, bubble_cnt_o=0.
2. Stream two instructions with stall_i=1 on the second edge -> outputs hold the first instruction for the stalled cycle, then show the second one cycle later.
3. Load lw (MemRead=1, rd=7), then flush_i=1 with stall_i=1 -> RegWrite_o=MemRead_o=0, rd_o=0, valid_o=0, bubble_cnt_o=1.
4. CNT_W=4, hold flush_i=1 for 20 cycles -> bubble_cnt_o reaches 15 and stays at 15.
5. Load jal (Jump=1, MemtoReg=10, pc_plus4=0x104), assert rst_i for one cycle mid-stream -> all outputs 0 next cycle; the following unstalled edge loads new inputs.
6. valid_i=0 with nop controls, no flush -> valid_o=0, bubble_cnt_o unchanged.
